// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_pkg                                                     |
// | Description : Widths and helpers shared by convolution_2D and max_pool_2x2 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package conv_pkg;

  localparam int PIXEL_W = 8;
  localparam int ACC_W   = 32;

  function automatic logic [PIXEL_W-1:0] pix_max(input logic [PIXEL_W-1:0] a,
                                                 input logic [PIXEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/requant_relu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : requant_relu                                                 |
// | Description : ReLU, arithmetic right-shift and 8-bit saturation            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module requant_relu
  import conv_pkg::*;
#(
  parameter int ACC_W_P   = ACC_W,
  parameter int PIXEL_W_P = PIXEL_W,
  parameter int SHIFT     = 4
) (
  input  logic [ACC_W_P-1:0]   acc,
  output logic [PIXEL_W_P-1:0] q
);

  localparam logic [ACC_W_P-1:0] c_sat_limit = ACC_W_P'({PIXEL_W_P{1'b1}});

  logic [ACC_W_P-1:0] w_relu;
  logic [ACC_W_P-1:0] w_shift;

  // After ReLU the value is non-negative, so a logical shift equals the arithmetic one.
  assign w_relu  = acc[ACC_W_P-1] ? '0 : acc;
  assign w_shift = w_relu >> SHIFT;
  assign q       = (w_shift > c_sat_limit) ? '1 : w_shift[PIXEL_W_P-1:0];

endmodule
`default_nettype wire

// File: rtl/max_pool_2x2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : max_pool_2x2                                                 |
// | Description : Requantise conv accumulators, then 2x2 stride-2 max pooling  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module max_pool_2x2
  import conv_pkg::*;
#(
  parameter int NUM_TREES  = 2,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int SHIFT      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ACC_W*NUM_TREES-1:0]   pixel_in,
  input  logic                         pixel_in_valid,
  output logic [PIXEL_W*NUM_TREES-1:0] pixel_out,
  output logic                         pixel_out_valid,
  output logic                         frame_done
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int K_W    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int VEC_W  = PIXEL_W * NUM_TREES;

  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [VEC_W-1:0] r_pair;
  logic [VEC_W-1:0] r_linebuf [HALF_W];

  logic [K_W-1:0]   w_k;
  logic [VEC_W-1:0] w_q_vec;
  logic [VEC_W-1:0] w_pm_vec;
  logic [VEC_W-1:0] w_pool_vec;
  logic [VEC_W-1:0] w_lb_rd;
  logic             w_col_last;
  logic             w_row_last;

  assign w_k        = K_W'(r_col >> 1);
  assign w_lb_rd    = r_linebuf[w_k];
  assign w_col_last = (r_col == c_col_last);
  assign w_row_last = (r_row == c_row_last);

  for (genvar t = 0; t < NUM_TREES; t++) begin : g_tree
    logic [PIXEL_W-1:0] w_q;
    logic [PIXEL_W-1:0] w_pm;

    requant_relu #(
      .ACC_W_P   (ACC_W),
      .PIXEL_W_P (PIXEL_W),
      .SHIFT     (SHIFT)
    ) u_requant (
      .acc (pixel_in[ACC_W*t +: ACC_W]),
      .q   (w_q)
    );

    assign w_pm                           = pix_max(r_pair[PIXEL_W*t +: PIXEL_W], w_q);
    assign w_q_vec[PIXEL_W*t +: PIXEL_W]    = w_q;
    assign w_pm_vec[PIXEL_W*t +: PIXEL_W]   = w_pm;
    assign w_pool_vec[PIXEL_W*t +: PIXEL_W] = pix_max(w_lb_rd[PIXEL_W*t +: PIXEL_W], w_pm);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col           <= '0;
      r_row           <= '0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      pixel_out_valid <= 1'b0;
      frame_done      <= 1'b0;
      if (pixel_in_valid) begin
        if (r_col[0] && r_row[0]) begin
          pixel_out       <= w_pool_vec;
          pixel_out_valid <= 1'b1;
          frame_done      <= w_col_last && w_row_last;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Pair and line storage need no reset: even columns/rows always write before they are read.
  always_ff @(posedge clock) begin
    if (pixel_in_valid) begin
      if (!r_col[0]) begin
        r_pair <= w_q_vec;
      end else if (!r_row[0]) begin
        r_linebuf[w_k] <= w_pm_vec;
      end
    end
  end

endmodule
`default_nettype wire
